// File: rtl/fifo_rd_packer_pkg.sv
// rtl/fifo_rd_packer_pkg.sv - shared constants and helpers for the FIFO read-side byte packer
package fifo_rd_packer_pkg;

    localparam int PACK_DEF       = 4;
    localparam int LINE_WORDS_DEF = 256;

    // Width able to hold a committed byte count of 0..pack inclusive.
    function automatic int lane_w(input int pack);
        return $clog2(pack + 1);
    endfunction

    typedef logic [lane_w(PACK_DEF)-1:0] cnt_eff_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO entries, packs PACK of them per word, streams words with line framing
// Optional partial-word flush is compiled in with FIFO_RD_PACKER_FLUSH_EN.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = PACK_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                       rd_clk,
    input  logic                       rd_rst_n,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    output logic                       fifo_rd_en,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       line_done,
    input  logic                       flush
);

    localparam int CW = lane_w(PACK);
    localparam int LW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int AW = DATA_WIDTH * (PACK - 1);

    localparam logic [CW-1:0] LANE_LAST = CW'(PACK - 1);
    localparam logic [CW-1:0] LANE_FULL = CW'(PACK);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_WORDS - 1);

    logic [CW-1:0]             acc_cnt;
    logic                      pend_q;
    logic [AW-1:0]             acc;
    logic [LW-1:0]             line_cnt;
    logic [CW-1:0]             cnt_eff;
    logic                      out_free;
    logic                      pop_ok;
    logic                      complete;
    logic                      accept;
    logic [LW-1:0]             line_nxt;
    logic                      flush_block;
    logic                      flush_emit;
    logic [DATA_WIDTH*PACK-1:0] partial;

    assign cnt_eff  = acc_cnt + CW'(pend_q);
    assign out_free = !m_valid || m_ready;
    assign complete = pend_q && (acc_cnt == LANE_LAST);
    assign accept   = m_valid && m_ready;

    // A completing word leaves through the output register, so the accumulator
    // is free again in that cycle and popping continues without a bubble.
    assign pop_ok = (cnt_eff == LANE_FULL) || (cnt_eff < LANE_LAST) ||
                    ((cnt_eff == LANE_LAST) && out_free);

    assign fifo_rd_en = rd_rst_n && !fifo_empty && pop_ok && !flush_block;

    assign line_nxt = accept ? (m_last ? '0 : line_cnt + LW'(1)) : line_cnt;

    always_comb begin
        partial = '0;
        for (int i = 0; i < PACK - 1; i++) begin
            if (CW'(i) < acc_cnt) begin
                partial[i*DATA_WIDTH +: DATA_WIDTH] = acc[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic flush_q;
    logic flush_done;

    // The latch waits for any in-flight pop to land before deciding what to emit.
    assign flush_block = flush || flush_q;
    assign flush_emit  = flush_q && !pend_q && (acc_cnt != '0) && out_free;
    assign flush_done  = flush_q && !pend_q && ((acc_cnt == '0) || out_free);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush || (flush_q && !flush_done);
        end
    end
`else
    logic flush_unused;

    assign flush_unused = flush;
    assign flush_block  = 1'b0;
    assign flush_emit   = 1'b0;
`endif

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            acc_cnt   <= '0;
            pend_q    <= 1'b0;
            acc       <= '0;
            line_cnt  <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            line_done <= 1'b0;
        end else begin
            pend_q    <= fifo_rd_en;
            line_cnt  <= line_nxt;
            line_done <= accept && m_last;
            if (complete) begin
                m_data  <= {fifo_dout, acc};
                m_valid <= 1'b1;
                m_last  <= (line_nxt == LINE_LAST);
                acc_cnt <= '0;
            end else if (flush_emit) begin
                m_data  <= partial;
                m_valid <= 1'b1;
                m_last  <= 1'b1;
                acc_cnt <= '0;
            end else begin
                if (accept) begin
                    m_valid <= 1'b0;
                end
                if (pend_q) begin
                    for (int i = 0; i < PACK - 1; i++) begin
                        if (acc_cnt == CW'(i)) begin
                            acc[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
                        end
                    end
                    acc_cnt <= acc_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - randomized self-checking bench for fifo_rd_packer against a byte-queue model
module tb_fifo_rd_packer;

    localparam int DW   = 8;
    localparam int PK   = 4;
    localparam int LWRD = 2;

    logic          rd_clk     = 1'b0;
    logic          rd_rst_n   = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout  = '0;
    logic          fifo_rd_en;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready    = 1'b1;
    logic          m_last;
    logic          line_done;
    logic          flush      = 1'b0;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .LINE_WORDS(LWRD)) dut (
        .rd_clk     (rd_clk),
        .rd_rst_n   (rd_rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .line_done  (line_done),
        .flush      (flush)
    );

    always #5 rd_clk = ~rd_clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fq[$];
    logic [7:0]  exp_bytes[$];
    int          acc_cyc[$];
    int          line_idx = 0;
    int          pops = 0;
    int          cyc = 0;
    int          accepts = 0;
    int          ld_cnt = 0;
    logic        gappy = 1'b0;
    logic        rand_mode = 1'b0;
    logic        gap_ph = 1'b0;
    logic        pop_s = 1'b0;
    logic [31:0] last_data = '0;
    logic        last_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        exp_bytes.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #2;
    endtask

    task automatic do_reset();
        rd_rst_n = 1'b0;
        fq.delete();
        exp_bytes.delete();
        line_idx  = 0;
        pops      = 0;
        gappy     = 1'b0;
        rand_mode = 1'b0;
        flush     = 1'b0;
        m_ready   = 1'b1;
        #1;
        chk("rst_rd_en",     {31'b0, fifo_rd_en}, 0);
        chk("rst_valid",     {31'b0, m_valid},    0);
        chk("rst_data",      m_data,              0);
        chk("rst_last",      {31'b0, m_last},     0);
        chk("rst_line_done", {31'b0, line_done},  0);
        repeat (3) @(posedge rd_clk);
        #2;
        rd_rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int target, input int budget, input string tag);
        int k = 0;
        while (accepts < target && k < budget) begin
            @(posedge rd_clk);
            k++;
        end
        chk(tag, {31'b0, accepts >= target}, 1);
        #2;
    endtask

    // FIFO model: the pop requested before an edge yields data just after that edge.
    initial begin
        forever begin
            @(negedge rd_clk);
            pop_s = fifo_rd_en;
            @(posedge rd_clk);
            #1;
            cyc++;
            if (pop_s && rd_rst_n) begin
                chk("pop_underflow", {31'b0, fq.size() > 0}, 1);
                if (fq.size() > 0) begin
                    fifo_dout = fq.pop_front();
                    pops++;
                end
            end
            gap_ph = !gap_ph;
            if (rand_mode) m_ready = ($urandom_range(0, 3) != 0);
            fifo_empty = (fq.size() == 0) || (gappy && gap_ph) ||
                         (rand_mode && ($urandom_range(0, 3) == 0));
        end
    end

    logic        stall_q = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    logic        ld_exp = 1'b0;
    logic [31:0] exp_w;
    logic        exp_last;
    int          n_b;

    initial begin
        forever begin
            @(negedge rd_clk);
            if (!rd_rst_n) begin
                stall_q = 1'b0;
                ld_exp  = 1'b0;
            end else begin
                chk("pop_when_empty", {31'b0, fifo_rd_en & fifo_empty}, 0);
                chk("line_done", {31'b0, line_done}, {31'b0, ld_exp});
                if (line_done) ld_cnt++;
                if (stall_q) begin
                    chk("hold_valid", {31'b0, m_valid}, 1);
                    chk("hold_data",  m_data, hold_data);
                    chk("hold_last",  {31'b0, m_last}, {31'b0, hold_last});
                end
                ld_exp = 1'b0;
                if (m_valid && m_ready) begin
                    n_b = (exp_bytes.size() < PK) ? exp_bytes.size() : PK;
                    chk("spurious_word", {31'b0, n_b > 0}, 1);
                    exp_w = '0;
                    for (int i = 0; i < n_b; i++) exp_w[i*8 +: 8] = exp_bytes.pop_front();
                    exp_last = (n_b < PK) || (line_idx == LWRD - 1);
                    line_idx = exp_last ? 0 : line_idx + 1;
                    chk("word_data", m_data, exp_w);
                    chk("word_last", {31'b0, m_last}, {31'b0, exp_last});
                    ld_exp    = exp_last;
                    last_data = m_data;
                    last_last = m_last;
                    acc_cyc.push_back(cyc);
                    accepts++;
                end
                stall_q   = m_valid && !m_ready;
                hold_data = m_data;
                hold_last = m_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int a0;
    int ld0;
    int cnt;
    int k;

    initial begin
        // Streaming: one pop per cycle, one word every PK cycles, line framing every 2 words.
        do_reset();
        a0 = accepts;
        ld0 = ld_cnt;
        for (int i = 0; i < 16; i++) push(8'(i));
        k = 0;
        do begin @(negedge rd_clk); k++; end while (!fifo_rd_en && k < 10);
        cnt = 0;
        while (fifo_rd_en && cnt < 20) begin cnt++; @(negedge rd_clk); end
        chk("stream_rd_en_run", cnt, 16);
        chk("stream_rd_en_stop", {31'b0, fifo_rd_en}, 0);
        #2;
        wait_acc(a0 + 4, 40, "stream_words");
        for (int i = 1; i < 4; i++)
            chk("stream_spacing", acc_cyc[a0 + i] - acc_cyc[a0 + i - 1], PK);
        tick(3);
        chk("line_done_count", ld_cnt - ld0, 2);

        // Backpressure: output stalled from the start, exactly one more word's worth minus one byte popped.
        do_reset();
        a0 = accepts;
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        tick(25);
        chk("bp_pops", pops, 7);
        chk("bp_rd_en_low", {31'b0, fifo_rd_en}, 0);
        chk("bp_valid", {31'b0, m_valid}, 1);
        m_ready = 1'b1;
        wait_acc(a0 + 4, 60, "bp_words");
        chk("bp_all_popped", pops, 16);

        // Gappy source.
        do_reset();
        a0 = accepts;
        gappy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        wait_acc(a0 + 4, 80, "gappy_words");
        gappy = 1'b0;

        // Async reset with a pop in flight, then fresh lane-0 word.
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        k = 0;
        do begin @(negedge rd_clk); k++; end while (!(pops == 7 && fifo_rd_en) && k < 40);
        chk("reset_point_reached", {31'b0, pops == 7}, 1);
        #2;
        do_reset();
        a0 = accepts;
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        wait_acc(a0 + 1, 30, "reset_fresh_wait");
        chk("reset_fresh_word", last_data, 32'h43424140);

        // Random traffic with random backpressure and gaps.
        do_reset();
        a0 = accepts;
        rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) push(8'($urandom_range(0, 255)));
        wait_acc(a0 + 50, 3000, "random_words");
        rand_mode = 1'b0;
        m_ready = 1'b1;
        tick(4);
        chk("random_model_drained", exp_bytes.size(), 0);

`ifdef FIFO_RD_PACKER_FLUSH_EN
        do_reset();
        a0 = accepts;
        ld0 = ld_cnt;
        push(8'hAA);
        push(8'hBB);
        tick(8);
        chk("flush_no_early_word", accepts, a0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_acc(a0 + 1, 20, "flush_word_wait");
        chk("flush_data", last_data, 32'h0000BBAA);
        chk("flush_last", {31'b0, last_last}, 1);
        tick(3);
        chk("flush_line_done", ld_cnt - ld0, 1);
        a0 = accepts;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(10);
        chk("flush_empty_no_word", accepts, a0);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
